bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_pkg.sv | 25 ++
 rtl/bram_rd_fifo.sv | 67 ++++++
 rtl/bram_stream_reader.sv | 127 ++++++++++++
 tb/tb_bram_stream_reader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared FSM encoding and read-FIFO sizing for the BRAM stream reader.
package bram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;
    typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

    localparam fifo_cnt_t FIFO_DEPTH_C = fifo_cnt_t'(FIFO_DEPTH);

    // Room for one more read once stored words and outstanding reads are both counted.
    function automatic logic rd_slot_free(input fifo_cnt_t occ,
                                          input logic      rd_pending,
                                          input logic      inflight);
        return (occ + fifo_cnt_t'(rd_pending) + fifo_cnt_t'(inflight)) < FIFO_DEPTH_C;
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small fixed-depth FIFO buffering BRAM read data ahead of the output stream.
module bram_rd_fifo
    import bram_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output fifo_cnt_t        count
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    fifo_ptr_t        wr_ptr_q, wr_ptr_d;
    fifo_ptr_t        rd_ptr_q, rd_ptr_d;
    fifo_cnt_t        cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == FIFO_DEPTH_C);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + fifo_ptr_t'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + fifo_ptr_t'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + fifo_cnt_t'(1);
            2'b01:   cnt_d = cnt_q - fifo_cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive BRAM words (wrapping at DEPTH) and streams them
// out with valid/ready flow control, never issuing more reads than the FIFO can hold.
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   len_t;

    state_e state_q, state_d;
    logic   enb_q, enb_d;
    addr_t  addrb_q, addrb_d;
    logic   inflight_q, inflight_d;
    len_t   rd_left_q, rd_left_d;
    len_t   beats_left_q, beats_left_d;
    logic   done_q, done_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    fifo_cnt_t             fifo_count;
    logic [DATA_WIDTH-1:0] fifo_dout;

    bram_rd_fifo #(
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (doutb),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // doutb holds when enb=0, so only the cycle after a real read is captured.
    assign fifo_push = inflight_q;
    assign fifo_pop  = m_valid && m_ready;

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_dout;
    assign m_last  = m_valid && (beats_left_q == len_t'(1));
    assign enb     = enb_q;
    assign addrb   = addrb_q;
    assign busy    = (state_q == READ);
    assign done    = done_q;

    always_comb begin
        state_d      = state_q;
        enb_d        = 1'b0;
        addrb_d      = addrb_q;
        inflight_d   = enb_q;
        rd_left_d    = rd_left_q;
        beats_left_d = beats_left_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d      = READ;
                        enb_d        = 1'b1;
                        addrb_d      = base_addr;
                        rd_left_d    = length - len_t'(1);
                        beats_left_d = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if ((rd_left_q != '0) && !fifo_full &&
                    rd_slot_free(fifo_count, enb_q, inflight_q)) begin
                    enb_d     = 1'b1;
                    addrb_d   = addrb_q + addr_t'(1);
                    rd_left_d = rd_left_q - len_t'(1);
                end
                if (fifo_pop) begin
                    beats_left_d = beats_left_q - len_t'(1);
                    if (m_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            enb_q        <= 1'b0;
            addrb_q      <= '0;
            inflight_q   <= 1'b0;
            rd_left_q    <= '0;
            beats_left_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            enb_q        <= enb_d;
            addrb_q      <= addrb_d;
            inflight_q   <= inflight_d;
            rd_left_q    <= rd_left_d;
            beats_left_q <= beats_left_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed end-to-end bench: stream reader paired with a registered-read BRAM model.
`timescale 1ns/1ps
module tb_bram_stream_reader;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LOG_N = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bram [DEPTH];

    always #5 clk = ~clk;

    bram_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .enb      (enb),
        .addrb    (addrb),
        .doutb    (doutb),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [DW-1:0] bram_word(input int unsigned a);
        logic [AW-1:0] x;
        x = AW'(a % DEPTH);
        return x[7:0] ^ {5'b0, x[10:8]};
    endfunction

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) bram[i] = bram_word(i);
        doutb = '0;
    end

    always @(posedge clk) begin
        if (enb) doutb <= bram[addrb];
    end

    // Monitor: logs issued reads, transferred beats and done pulses; checks hold-while-stalled.
    int            cyc = 0;
    int            nbeats = 0;
    int            issued = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            max_occ = 0;
    int            stable_err = 0;
    int            occ;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] beat_data  [LOG_N];
    logic          beat_last  [LOG_N];
    int            beat_cyc   [LOG_N];
    logic [AW-1:0] issue_addr [LOG_N];

    always @(negedge clk) begin
        if (!rst_n) begin
            nbeats = 0; issued = 0; done_cnt = 0; max_occ = 0; prev_stall = 1'b0;
        end else begin
            cyc++;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stable_err++;
            occ = issued - nbeats + (enb ? 1 : 0);
            if (occ > max_occ) max_occ = occ;
            if (enb && issued < int'(LOG_N)) begin
                issue_addr[issued] = addrb;
                issued++;
            end
            if (m_valid && m_ready && nbeats < int'(LOG_N)) begin
                beat_data[nbeats] = m_data;
                beat_last[nbeats] = m_last;
                beat_cyc[nbeats]  = cyc;
                nbeats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int unsigned base, input int unsigned len);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        step();
        start = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int n = 0;
        while (nbeats < target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_beats_reached"}, nbeats >= target, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_burst(input string tag, input int first, input int unsigned base,
                               input int len);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_data[%0d]", tag, i), beat_data[first+i],
                  bram_word(base + i));
            check($sformatf("%s_last[%0d]", tag, i), beat_last[first+i], i == len - 1);
        end
    endtask

    initial begin
        int b0, i0, d0;
        int unsigned exp_addr [4];
        logic [11:0] pat;
        int n;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
        #1;
        check("rst_enb", enb, 0);
        check("rst_addrb", addrb, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // 16 words from 0, full throughput
        m_ready = 1'b1; b0 = nbeats; i0 = issued;
        start_burst(0, 16);
        check("t1_busy", busy, 1);
        check("t1_enb", enb, 1);
        check("t1_addrb", addrb, 0);
        step();
        check("t1_valid_e1", m_valid, 0);
        step();
        check("t1_valid_e2", m_valid, 1);
        check("t1_first_data", m_data, 0);
        wait_beats("t1", b0 + 16, 40);
        check("t1_done_now", done, 1);
        check("t1_busy_off", busy, 0);
        step();
        check("t1_done_pulse", done, 0);
        check_burst("t1", b0, 0, 16);
        check("t1_back_to_back", beat_cyc[b0+15] - beat_cyc[b0], 15);
        check("t1_done_timing", done_cyc - beat_cyc[b0+15], 1);
        check("t1_reads", issued - i0, 16);

        // address wrap at DEPTH-1
        b0 = nbeats; i0 = issued;
        exp_addr = '{2046, 2047, 0, 1};
        start_burst(2046, 4);
        wait_beats("t2", b0 + 4, 20);
        step();
        for (int k = 0; k < 4; k++)
            check($sformatf("t2_addr[%0d]", k), issue_addr[i0+k], exp_addr[k]);
        check_burst("t2", b0, 2046, 4);
        wait_idle("t2", 10);

        // backpressure: long stall then irregular ready
        m_ready = 1'b0; b0 = nbeats; i0 = issued;
        start_burst(100, 8);
        repeat (10) step();
        check("t3_stall_reads", issued - i0, 4);
        check("t3_stall_valid", m_valid, 1);
        check("t3_stall_data", m_data, bram_word(100));
        pat = 12'b1001_0110_1101;
        n = 0;
        while (nbeats < b0 + 8 && n < 80) begin
            m_ready = pat[n % 12];
            step();
            n++;
        end
        check("t3_beats_reached", nbeats >= b0 + 8, 1);
        m_ready = 1'b1;
        wait_idle("t3", 10);
        repeat (3) step();
        check("t3_beat_count", nbeats - b0, 8);
        check_burst("t3", b0, 100, 8);
        check("t3_reads", issued - i0, 8);
        check("t3_stable", stable_err, 0);
        check("t3_max_occ", max_occ, 4);

        // zero length
        i0 = issued; d0 = done_cnt;
        start_burst(5, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 1);
        check("t4_enb", enb, 0);
        step();
        check("t4_done_pulse", done, 0);
        check("t4_reads", issued - i0, 0);
        check("t4_done_count", done_cnt - d0, 1);

        // start while busy is ignored
        b0 = nbeats; i0 = issued;
        start_burst(10, 6);
        step();
        start_burst(500, 3);
        wait_beats("t5", b0 + 6, 30);
        repeat (6) step();
        check("t5_beat_count", nbeats - b0, 6);
        check("t5_reads", issued - i0, 6);
        check_burst("t5", b0, 10, 6);
        check("t5_busy", busy, 0);

        // start accepted in the done cycle
        b0 = nbeats;
        start_burst(20, 2);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("t6_done_seen", done, 1);
        start_burst(30, 3);
        check("t6_busy_again", busy, 1);
        wait_beats("t6", b0 + 5, 20);
        wait_idle("t6", 10);
        check_burst("t6a", b0, 20, 2);
        check_burst("t6b", b0 + 2, 30, 3);

        // reset mid-burst
        b0 = nbeats;
        start_burst(300, 10);
        wait_beats("t7", b0 + 3, 20);
        rst_n = 1'b0;
        #1;
        check("t7_rst_enb", enb, 0);
        check("t7_rst_addrb", addrb, 0);
        check("t7_rst_valid", m_valid, 0);
        check("t7_rst_last", m_last, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_done", done, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (4) step();
        check("t7_no_done", done_cnt, 0);
        check("t7_no_reads", issued, 0);
        check("t7_no_beats", nbeats, 0);
        b0 = nbeats;
        start_burst(40, 5);
        step();
        check("t7_valid_e1", m_valid, 0);
        step();
        check("t7_valid_e2", m_valid, 1);
        wait_beats("t7", b0 + 5, 20);
        repeat (4) step();
        check("t7_beat_count", nbeats - b0, 5);
        check_burst("t7", b0, 40, 5);
        check("t7_done_count", done_cnt, 1);

        // full-depth burst
        b0 = nbeats; i0 = issued; d0 = done_cnt;
        start_burst(0, 2048);
        wait_beats("t8", b0 + 2048, 2200);
        repeat (4) step();
        check("t8_beat_count", nbeats - b0, 2048);
        check("t8_reads", issued - i0, 2048);
        check_burst("t8", b0, 0, 2048);
        check("t8_back_to_back", beat_cyc[b0+2047] - beat_cyc[b0], 2047);
        check("t8_done_count", done_cnt - d0, 1);
        check("t8_busy", busy, 0);
        check("t8_stable", stable_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
